axil_memtest: RTL and testbench



---
 rtl/axil_memtest_pkg.sv | 25 ++
 rtl/axil_memtest_pattern.sv | 56 +++++
 rtl/axil_memtest.sv | 186 ++++++++++++++++++
 tb/tb_axil_memtest.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_memtest_pkg.sv
// rtl/axil_memtest_pkg.sv - FSM states, response code and pattern constants for axil_memtest
package axil_memtest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam int LFSR_WIDTH = 32;
    localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 32'h8020_0003;

    localparam logic [31:0] ADDR_PATTERN_KEY = 32'hA5A5_A5A5;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/axil_memtest_pattern.sv
// rtl/axil_memtest_pattern.sv - per-word test data; LFSR source when AXIL_MEMTEST_LFSR_EN is defined
module axil_memtest_pattern
    import axil_memtest_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]           SEED       = 32'h1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reseed,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] index,
    output logic [DATA_WIDTH-1:0] data
);

    logic [31:0] word;

`ifdef AXIL_MEMTEST_LFSR_EN
    logic [LFSR_WIDTH-1:0] lfsr;
    logic                  unused_cfg;

    assign unused_cfg = ^{index, BASE_ADDR, 8'(STRB_WIDTH)};

    // Reseed wins over advance so the read phase replays the write sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (reseed) begin
            lfsr <= SEED;
        end else if (advance) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign word = lfsr;
`else
    localparam int STRB_SHIFT = $clog2(STRB_WIDTH);

    logic [ADDR_WIDTH-1:0] addr;
    logic                  unused_ctrl;

    assign unused_ctrl = ^{clk, rst, reseed, advance, SEED};
    assign addr        = BASE_ADDR + (index << STRB_SHIFT);
    assign word        = 32'(addr) ^ ADDR_PATTERN_KEY;
`endif

    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data[i] = word[i % 32];
        end
    end

endmodule

// File: rtl/axil_memtest.sv
// rtl/axil_memtest.sv - AXI-Lite write/read-back memory tester; pattern source selected by AXIL_MEMTEST_LFSR_EN
module axil_memtest
    import axil_memtest_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    WORD_COUNT = 16,
    parameter logic [31:0]           SEED       = 32'h1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam int                    STRB_SHIFT = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(WORD_COUNT - 1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  aw_done, w_done;
    logic                  load, reseed, advance, step_index, word_err;

    assign word_addr      = BASE_ADDR + (index << STRB_SHIFT);
    assign m_axil_awaddr  = word_addr;
    assign m_axil_araddr  = word_addr;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_wdata   = pattern;
    assign m_axil_wstrb   = '1;
    assign pass           = done && (err_count == 16'h0000);

    axil_memtest_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .SEED       (SEED)
    ) u_pattern (
        .clk     (clk),
        .rst     (rst),
        .reseed  (reseed),
        .advance (advance),
        .index   (index),
        .data    (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load           = 1'b0;
        reseed         = 1'b0;
        advance        = 1'b0;
        step_index     = 1'b0;
        word_err       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    load       = 1'b1;
                    reseed     = 1'b1;
                    state_next = WR_REQ;
                end
            end
            WR_REQ: begin
                busy           = 1'b1;
                m_axil_awvalid = !aw_done;
                m_axil_wvalid  = !w_done;
                if ((aw_done || m_axil_awready) && (w_done || m_axil_wready)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                busy          = 1'b1;
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) begin
                    word_err   = (m_axil_bresp != RESP_OKAY);
                    advance    = 1'b1;
                    step_index = 1'b1;
                    if (index == LAST_INDEX) begin
                        reseed     = 1'b1;
                        state_next = RD_REQ;
                    end else begin
                        state_next = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                busy           = 1'b1;
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                busy          = 1'b1;
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) begin
                    word_err   = (m_axil_rdata != pattern) || (m_axil_rresp != RESP_OKAY);
                    advance    = 1'b1;
                    step_index = 1'b1;
                    state_next = (index == LAST_INDEX) ? DONE : RD_REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // aw_done/w_done remember which half of the write has already handshaken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
        end else begin
            if (load) begin
                index          <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
            end else begin
                if (step_index) begin
                    index <= (index == LAST_INDEX) ? '0 : index + 1'b1;
                end
                if (word_err) begin
                    if (err_count == 16'h0000) begin
                        first_err_addr <= word_addr;
                    end
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                end
            end
            if (state_next != WR_REQ) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (m_axil_awvalid && m_axil_awready) aw_done <= 1'b1;
                if (m_axil_wvalid && m_axil_wready)   w_done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_memtest.sv
// tb/tb_axil_memtest.sv - self-checking bench for axil_memtest with a behavioural AXI-Lite slave
module tb_axil_memtest;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [2];
    logic        busy [2], done [2], pass [2];
    logic [15:0] err_count [2], first_err_addr [2];
    logic [15:0] awaddr [2], araddr [2];
    logic [2:0]  awprot [2], arprot [2];
    logic [31:0] wdata [2], rdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  bresp [2], rresp [2];
    logic        awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
    logic        arvalid [2], arready [2], rvalid [2], rready [2];

    logic [31:0] mem [2][16384];
    logic        aw_got [2], w_got [2], stall [2];
    logic [15:0] aw_a [2];
    logic [31:0] w_d [2];
    int          w_age [2], w_cnt [2], aw_only_cnt [2];
    logic [16:0] aw_log [$], ar_log [$];

    logic [15:0] bresp_mask = '0, rd_corrupt_mask = '0;
    logic        aw_delay_en = 1'b0, rand_en = 1'b0;

    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    axil_memtest u_dut (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err_count[0]), .first_err_addr(first_err_addr[0]),
        .m_axil_awaddr(awaddr[0]), .m_axil_awprot(awprot[0]), .m_axil_awvalid(awvalid[0]),
        .m_axil_awready(awready[0]), .m_axil_wdata(wdata[0]), .m_axil_wstrb(wstrb[0]),
        .m_axil_wvalid(wvalid[0]), .m_axil_wready(wready[0]), .m_axil_bresp(bresp[0]),
        .m_axil_bvalid(bvalid[0]), .m_axil_bready(bready[0]), .m_axil_araddr(araddr[0]),
        .m_axil_arprot(arprot[0]), .m_axil_arvalid(arvalid[0]), .m_axil_arready(arready[0]),
        .m_axil_rdata(rdata[0]), .m_axil_rresp(rresp[0]), .m_axil_rvalid(rvalid[0]),
        .m_axil_rready(rready[0])
    );

    axil_memtest #(.BASE_ADDR(16'hFFF8), .WORD_COUNT(4)) u_dut_wrap (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err_count[1]), .first_err_addr(first_err_addr[1]),
        .m_axil_awaddr(awaddr[1]), .m_axil_awprot(awprot[1]), .m_axil_awvalid(awvalid[1]),
        .m_axil_awready(awready[1]), .m_axil_wdata(wdata[1]), .m_axil_wstrb(wstrb[1]),
        .m_axil_wvalid(wvalid[1]), .m_axil_wready(wready[1]), .m_axil_bresp(bresp[1]),
        .m_axil_bvalid(bvalid[1]), .m_axil_bready(bready[1]), .m_axil_araddr(araddr[1]),
        .m_axil_arprot(arprot[1]), .m_axil_arvalid(arvalid[1]), .m_axil_arready(arready[1]),
        .m_axil_rdata(rdata[1]), .m_axil_rresp(rresp[1]), .m_axil_rvalid(rvalid[1]),
        .m_axil_rready(rready[1])
    );

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            awready[g] = !aw_got[g] && !bvalid[g] && !stall[g] &&
                         (!aw_delay_en || (w_got[g] && w_age[g] >= 3));
            wready[g]  = !w_got[g] && !bvalid[g] && !stall[g];
            arready[g] = !rvalid[g] && !stall[g];
        end
    end

    // Fault injection (bresp / rdata bit 0) applies to the default-parameter instance only.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                aw_got[g] <= 1'b0;
                w_got[g]  <= 1'b0;
                stall[g]  <= 1'b0;
                bvalid[g] <= 1'b0;
                rvalid[g] <= 1'b0;
                bresp[g]  <= 2'b00;
                rresp[g]  <= 2'b00;
                rdata[g]  <= '0;
                w_age[g]  <= 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                stall[g] <= rand_en && ($urandom_range(0, 3) == 0);
                if (awvalid[g] && !wvalid[g]) aw_only_cnt[g] <= aw_only_cnt[g] + 1;
                if (awvalid[g] && awready[g]) begin
                    aw_got[g] <= 1'b1;
                    aw_a[g]   <= awaddr[g];
                    aw_log.push_back({1'(g), awaddr[g]});
                end
                if (wvalid[g] && wready[g]) begin
                    w_got[g] <= 1'b1;
                    w_d[g]   <= wdata[g];
                    w_cnt[g] <= w_cnt[g] + 1;
                end
                if (w_got[g] && !aw_got[g]) w_age[g] <= w_age[g] + 1;
                if (aw_got[g] && w_got[g] && !bvalid[g]) begin
                    mem[g][aw_a[g][15:2]] <= w_d[g];
                    bvalid[g] <= 1'b1;
                    bresp[g]  <= (g == 0 && bresp_mask[aw_a[g][5:2]]) ? 2'b10 : 2'b00;
                    aw_got[g] <= 1'b0;
                    w_got[g]  <= 1'b0;
                    w_age[g]  <= 0;
                end else if (bvalid[g] && bready[g]) begin
                    bvalid[g] <= 1'b0;
                end
                if (arvalid[g] && arready[g]) begin
                    rvalid[g] <= 1'b1;
                    rresp[g]  <= 2'b00;
                    rdata[g]  <= mem[g][araddr[g][15:2]] ^
                                 {31'b0, (g == 0) && rd_corrupt_mask[araddr[g][5:2]]};
                    ar_log.push_back({1'(g), araddr[g]});
                end else if (rvalid[g] && rready[g]) begin
                    rvalid[g] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [15:0] model_addr(input logic [15:0] base, input int i);
        return base + 16'(i * 4);
    endfunction

    function automatic logic [31:0] model_pattern(input logic [15:0] base, input int i);
`ifdef AXIL_MEMTEST_LFSR_EN
        logic [31:0] s;
        s = 32'h1;
        for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        return s ^ {16'h0, base & 16'h0};
`else
        return {16'h0, model_addr(base, i)} ^ 32'hA5A5_A5A5;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input int g);
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int g, output int cycles);
        cycles = 0;
        while (!done[g] && cycles < 5000) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_done"}, 32'(done[g]), 32'd1);
    endtask

    task automatic check_idle(input string tag, input int g);
        check({tag, "_ctrl"}, {busy[g], done[g], pass[g], awvalid[g], wvalid[g], bready[g],
                               arvalid[g], rready[g]}, 32'h0);
        check({tag, "_err_count"}, err_count[g], 32'h0);
        check({tag, "_first_err"}, first_err_addr[g], 32'h0);
    endtask

    task automatic verify(input string tag, input int g, input logic [15:0] base, input int n,
                          input logic [15:0] bm, input logic [15:0] cm,
                          input int aw0, input int ar0, input int w0);
        int          exp_err, k;
        logic [15:0] exp_first, a;
        logic [16:0] e;
        exp_err   = $countones(bm) + $countones(cm);
        exp_first = '0;
        for (int i = n - 1; i >= 0; i--) if (cm[i]) exp_first = model_addr(base, i);
        for (int i = n - 1; i >= 0; i--) if (bm[i]) exp_first = model_addr(base, i);
        check({tag, "_pass"}, 32'(pass[g]), 32'(exp_err == 0));
        check({tag, "_err_count"}, err_count[g], exp_err);
        check({tag, "_first_err"}, first_err_addr[g], exp_first);
        check({tag, "_wstrb_prot"}, {wstrb[g], awprot[g], arprot[g]}, 32'hF << 6);
        k = 0;
        for (int j = aw0; j < aw_log.size(); j++) begin
            e = aw_log[j];
            if (e[16] == 1'(g)) begin
                check({tag, "_awaddr"}, e[15:0], model_addr(base, k));
                k++;
            end
        end
        check({tag, "_aw_count"}, k, n);
        k = 0;
        for (int j = ar0; j < ar_log.size(); j++) begin
            e = ar_log[j];
            if (e[16] == 1'(g)) begin
                check({tag, "_araddr"}, e[15:0], model_addr(base, k));
                k++;
            end
        end
        check({tag, "_ar_count"}, k, n);
        check({tag, "_w_count"}, w_cnt[g] - w0, n);
        for (int i = 0; i < n; i++) begin
            a = model_addr(base, i);
            check({tag, "_mem"}, mem[g][a[15:2]], model_pattern(base, i));
        end
    endtask

    initial begin
        int          cyc, cyc2, aw0, ar0, w0, snap, found;
        logic [15:0] bm, cm;
        start[0] = 1'b0;
        start[1] = 1'b0;
        w_cnt[0] = 0; w_cnt[1] = 0;
        aw_only_cnt[0] = 0; aw_only_cnt[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset0", 0);
        check_idle("reset1", 1);
        rst = 1'b0;
        @(posedge clk); #1;

        aw0 = aw_log.size(); ar0 = ar_log.size(); w0 = w_cnt[0];
        kick(0);
        wait_done("basic", 0, cyc);
        check("basic_cycles", cyc, 16 * 5);
        verify("basic", 0, 16'h0000, 16, '0, '0, aw0, ar0, w0);

        bresp_mask = 16'h0008;
        aw0 = aw_log.size(); ar0 = ar_log.size(); w0 = w_cnt[0];
        kick(0);
        repeat (7) @(posedge clk);
        #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_done("bresp", 0, cyc2);
        check("busy_start_ignored_cycles", 8 + cyc2, 16 * 5);
        verify("bresp", 0, 16'h0000, 16, 16'h0008, '0, aw0, ar0, w0);
        bresp_mask = '0;

        rd_corrupt_mask = 16'h0220;
        aw0 = aw_log.size(); ar0 = ar_log.size(); w0 = w_cnt[0];
        kick(0);
        wait_done("corrupt", 0, cyc);
        verify("corrupt", 0, 16'h0000, 16, '0, 16'h0220, aw0, ar0, w0);

        rand_en = 1'b1;
        for (int it = 0; it < 3; it++) begin
            bm = 16'($urandom & $urandom & $urandom);
            cm = 16'($urandom & $urandom & $urandom);
            bresp_mask = bm;
            rd_corrupt_mask = cm;
            aw0 = aw_log.size(); ar0 = ar_log.size(); w0 = w_cnt[0];
            kick(0);
            wait_done("random", 0, cyc);
            verify("random", 0, 16'h0000, 16, bm, cm, aw0, ar0, w0);
        end
        rand_en = 1'b0;
        bresp_mask = '0;
        rd_corrupt_mask = '0;

        aw_delay_en = 1'b1;
        snap = aw_only_cnt[0];
        aw0 = aw_log.size(); ar0 = ar_log.size(); w0 = w_cnt[0];
        kick(0);
        wait_done("awdelay", 0, cyc);
        check("awdelay_aw_held_alone", 32'(aw_only_cnt[0] - snap >= 16 * 3), 32'd1);
        verify("awdelay", 0, 16'h0000, 16, '0, '0, aw0, ar0, w0);
        aw_delay_en = 1'b0;

        aw0 = aw_log.size(); ar0 = ar_log.size(); w0 = w_cnt[1];
        kick(1);
        wait_done("wrap", 1, cyc);
        check("wrap_cycles", cyc, 4 * 5);
        verify("wrap", 1, 16'hFFF8, 4, '0, '0, aw0, ar0, w0);

        rd_corrupt_mask = 16'h0004;
        kick(0);
        found = 0;
        for (int c = 0; c < 2000 && found == 0; c++) begin
            if (rready[0] && araddr[0] == 16'h001C) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rst_reached_rd_word7", found, 1);
        check("rst_pre_err_count", err_count[0], 32'd1);
        rst = 1'b1;
        #1;
        check_idle("rst_mid_async", 0);
        @(posedge clk); #1;
        check_idle("rst_mid_held", 0);
        rst = 1'b0;
        rd_corrupt_mask = '0;
        @(posedge clk); #1;
        aw0 = aw_log.size(); ar0 = ar_log.size(); w0 = w_cnt[0];
        kick(0);
        wait_done("after_rst", 0, cyc);
        verify("after_rst", 0, 16'h0000, 16, '0, '0, aw0, ar0, w0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
